// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hack_pkg
//  Description : Shared types and constants for the Hack CPU boot loader:
//                FSM state encoding, error codes and the default sync byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

   typedef enum logic [3:0] {
      WAIT_SYNC = 4'd0,
      LEN_HI    = 4'd1,
      LEN_LO    = 4'd2,
      DATA_HI   = 4'd3,
      DATA_LO   = 4'd4,
      WRITE     = 4'd5,
      CHECK     = 4'd6,
      RUN       = 4'd7,
      ERROR     = 4'd8
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CHKSUM  = 2'd3;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h48;

   // States inside a frame where the inter-byte timeout is running.
   function automatic logic is_timed(input state_t s);
      return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
             (s == DATA_LO) || (s == CHECK);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hack_boot_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : hack_boot_timeout
//  Description : Loadable down-counter. clr_i reloads the budget, en_i lets it
//                count; expired_o flags the cycle on which the budget is used
//                up. TIMEOUT_CYCLES = 0 disables the timeout entirely.
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_boot_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
)(
   input  logic CLK,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_disabled
         logic unused_inputs;
         assign unused_inputs = ^{CLK, reset, clr_i, en_i};
         assign expired_o     = 1'b0;
      end else begin : g_counter
         localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
         localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES - 1);

         logic [TW-1:0] cnt_q;

         // Reload on every accepted byte, count down while enabled.
         always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
               cnt_q <= LOAD_VAL;
            end else if (clr_i) begin
               cnt_q <= LOAD_VAL;
            end else if (en_i && (cnt_q != '0)) begin
               cnt_q <= cnt_q - TW'(1);
            end
         end

         assign expired_o = en_i && (cnt_q == '0);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/hack_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : hack_boot_loader
//  Description : Boot sequencer for the Hack CPU. Holds the CPU in reset,
//                receives a framed program over a valid/ready byte stream,
//                writes 16-bit words to instruction memory from address 0,
//                then releases the CPU. boot_req re-enters load mode.
//                Optional macro HACK_BOOT_CHECKSUM_EN adds a trailing XOR
//                checksum byte to the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_boot_loader
   import hack_pkg::*;
#(
   parameter int unsigned ROM_AWIDTH     = 15,
   parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
)(
   input  logic                  CLK,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  boot_req,
   output logic [ROM_AWIDTH-1:0] rom_addr,
   output logic [15:0]           rom_wdata,
   output logic                  rom_we,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  error,
   output logic [1:0]            error_code
);

   // Index is one bit wider than the address so N = 2**ROM_AWIDTH terminates.
   localparam int unsigned IW        = ROM_AWIDTH + 1;
   localparam int unsigned MAX_WORDS = 2 ** ROM_AWIDTH;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [15:0]           len_q, len_d;
   logic [7:0]            hi_q, hi_d;
   logic [ROM_AWIDTH-1:0] rom_addr_q, rom_addr_d;
   logic [15:0]           rom_wdata_q, rom_wdata_d;
   logic                  rom_we_q, rom_we_d;
   logic [1:0]            err_q, err_d;
   logic                  rx_ready_q, cpu_reset_q, busy_q, error_q;
`ifdef HACK_BOOT_CHECKSUM_EN
   logic [7:0]            chk_q, chk_d;
`endif

   logic                  w_accept;
   logic                  w_expired;
   logic [15:0]           w_len_next;
   logic [IW-1:0]         w_idx_inc;
   logic                  w_last;

   assign w_accept   = rx_valid && rx_ready_q;
   assign w_len_next = {len_q[15:8], rx_data};
   assign w_idx_inc  = idx_q + IW'(1);
   assign w_last     = (32'(w_idx_inc) == 32'(len_q));

   hack_boot_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK       (CLK),
      .reset     (reset),
      .clr_i     (w_accept),
      .en_i      (is_timed(state_q)),
      .expired_o (w_expired)
   );

   // Next-state logic; an accepted byte always wins over the timeout.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      hi_d        = hi_q;
      rom_addr_d  = rom_addr_q;
      rom_wdata_d = rom_wdata_q;
      rom_we_d    = 1'b0;
      err_d       = err_q;
`ifdef HACK_BOOT_CHECKSUM_EN
      chk_d       = chk_q;
`endif
      case (state_q)
         WAIT_SYNC: begin
            if (w_accept && (rx_data == SYNC_BYTE)) begin
               state_d = LEN_HI;
               idx_d   = '0;
               len_d   = '0;
`ifdef HACK_BOOT_CHECKSUM_EN
               chk_d   = '0;
`endif
            end
         end
         LEN_HI: begin
            if (w_accept) begin
               len_d   = {rx_data, 8'h00};
               state_d = LEN_LO;
            end else if (w_expired) begin
               state_d = ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
         LEN_LO: begin
            if (w_accept) begin
               len_d = w_len_next;
               if ((w_len_next == 16'd0) || (32'(w_len_next) > MAX_WORDS)) begin
                  state_d = ERROR;
                  err_d   = ERR_LEN;
               end else begin
                  state_d = DATA_HI;
               end
            end else if (w_expired) begin
               state_d = ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
         DATA_HI: begin
            if (w_accept) begin
               hi_d    = rx_data;
               state_d = DATA_LO;
`ifdef HACK_BOOT_CHECKSUM_EN
               chk_d   = chk_q ^ rx_data;
`endif
            end else if (w_expired) begin
               state_d = ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
         DATA_LO: begin
            if (w_accept) begin
               rom_wdata_d = {hi_q, rx_data};
               rom_addr_d  = idx_q[ROM_AWIDTH-1:0];
               rom_we_d    = 1'b1;
               state_d     = WRITE;
`ifdef HACK_BOOT_CHECKSUM_EN
               chk_d       = chk_q ^ rx_data;
`endif
            end else if (w_expired) begin
               state_d = ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
         WRITE: begin
            idx_d = w_idx_inc;
            if (w_last) begin
`ifdef HACK_BOOT_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = RUN;
`endif
            end else begin
               state_d = DATA_HI;
            end
         end
`ifdef HACK_BOOT_CHECKSUM_EN
         CHECK: begin
            if (w_accept) begin
               if (rx_data == chk_q) begin
                  state_d = RUN;
               end else begin
                  state_d = ERROR;
                  err_d   = ERR_CHKSUM;
               end
            end else if (w_expired) begin
               state_d = ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
`endif
         RUN: begin
            if (boot_req) begin
               state_d = WAIT_SYNC;
            end
         end
         ERROR: begin
            if (boot_req) begin
               state_d = WAIT_SYNC;
               err_d   = ERR_NONE;
            end
         end
         default: begin
            state_d = WAIT_SYNC;
         end
      endcase
   end

   // State, datapath and registered outputs (outputs follow the next state).
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_SYNC;
         idx_q       <= '0;
         len_q       <= '0;
         hi_q        <= '0;
         rom_addr_q  <= '0;
         rom_wdata_q <= '0;
         rom_we_q    <= 1'b0;
         err_q       <= ERR_NONE;
         rx_ready_q  <= 1'b1;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b1;
         error_q     <= 1'b0;
`ifdef HACK_BOOT_CHECKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         hi_q        <= hi_d;
         rom_addr_q  <= rom_addr_d;
         rom_wdata_q <= rom_wdata_d;
         rom_we_q    <= rom_we_d;
         err_q       <= err_d;
         rx_ready_q  <= !((state_d == WRITE) || (state_d == RUN));
         cpu_reset_q <= (state_d != RUN);
         busy_q      <= !((state_d == RUN) || (state_d == ERROR));
         error_q     <= (state_d == ERROR);
`ifdef HACK_BOOT_CHECKSUM_EN
         chk_q       <= chk_d;
`endif
      end
   end

   assign rx_ready   = rx_ready_q;
   assign rom_addr   = rom_addr_q;
   assign rom_wdata  = rom_wdata_q;
   assign rom_we     = rom_we_q;
   assign cpu_reset  = cpu_reset_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign error_code = err_q;

endmodule
`default_nettype wire
